matrix_loader: RTL and testbench

- Upstream feeder for compute_unit. Accepts a valid/ready element stream and writes operand matrix A, then B, row-major into the compute unit's operand memories.
- After both matrices are written, issues a 1-cycle start pulse and waits for the compute unit's done.
- Reports busy/complete status and the compute latency in cycles.

---
 rtl/matrix_loader.sv | 99 +++++++++
 tb/tb_matrix_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader.sv
// Streams operand matrices A then B row-major into compute_unit memories, then starts it and times the run.
// Latency: one cycle from an accepted element to its write strobe; start follows the last accept by one cycle.
// Backpressure: s_ready is high only while loading A or B, so no element past 2*N*N is ever taken.
module matrix_loader #(
  parameter int N  = 16,
  parameter int DW = 8,
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          a_we,
  output logic          b_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          start,
  input  logic          cu_done,
  output logic          busy,
  output logic          run_done,
  output logic [31:0]   cycle_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_WAIT   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [AW-1:0] LAST_ELEM = AW'(N*N-1);

  logic [2:0]    state;
  logic [AW-1:0] elem_cnt;
  logic          arm;
  logic          in_load;
  logic          accept;
  logic          last_elem;

  assign in_load   = (state == ST_LOAD_A) || (state == ST_LOAD_B);
  assign accept    = s_valid & in_load;
  assign last_elem = (elem_cnt == LAST_ELEM);

  assign s_ready  = in_load;
  assign start    = (state == ST_START);
  assign busy     = (state != ST_IDLE);
  assign run_done = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      elem_cnt    <= '0;
      arm         <= 1'b0;
      a_we        <= 1'b0;
      b_we        <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cycle_count <= '0;
    end else begin
      a_we <= accept && (state == ST_LOAD_A);
      b_we <= accept && (state == ST_LOAD_B);
      if (accept) begin
        mem_addr  <= elem_cnt;
        mem_wdata <= s_data;
        elem_cnt  <= last_elem ? '0 : elem_cnt + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (go) begin
            state    <= ST_LOAD_A;
            elem_cnt <= '0;
          end
        end
        ST_LOAD_A: if (accept && last_elem) state <= ST_LOAD_B;
        ST_LOAD_B: if (accept && last_elem) state <= ST_START;
        ST_START: begin
          cycle_count <= '0;
          arm         <= 1'b0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // arm only after done has been seen low, so a stale done level cannot end the run
          if (arm && cu_done) begin
            state <= ST_DONE;
          end else begin
            if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
            if (!cu_done) arm <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: the driver queues each element's expected write, a monitor pops on strobes.
module tb_matrix_loader;

  localparam int N  = 16;
  localparam int NN = N * N;

  typedef struct packed {
    logic       is_b;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        go;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        a_we;
  logic        b_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        start;
  logic        cu_done;
  logic        busy;
  logic        run_done;
  logic [31:0] cycle_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_a = 0;
  int n_b = 0;
  int n_start = 0;
  int n_done = 0;
  int start_cyc = 0;
  int last_acc_cyc = 0;
  logic [7:0] prev_addr;
  logic [7:0] prev_data;
  bit prev_ok = 0;
  wr_t exp_q[$];

  matrix_loader #(.N(N), .DW(8)) dut (
    .clk(clk), .rst(rst), .go(go),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .a_we(a_we), .b_we(b_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .start(start), .cu_done(cu_done), .busy(busy), .run_done(run_done),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding element.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_ok = 0;
    end else begin
      if (a_we || b_we) begin
        if (a_we) n_a++;
        if (b_we) n_b++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %0d data %0d with no element pending", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write", 32'({b_we, mem_addr, mem_wdata}), 32'({e.is_b, e.addr, e.data}));
        end
        chk("we_exclusive", 32'(a_we & b_we), 32'd0);
      end else if (prev_ok) begin
        chk("hold", 32'({mem_addr, mem_wdata}), 32'({prev_addr, prev_data}));
      end
      prev_addr = mem_addr;
      prev_data = mem_wdata;
      prev_ok   = 1;
    end
    if (start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (run_done) n_done++;
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s_ready"},     32'(s_ready),   32'd0);
    chk({tag, "_a_we"},        32'(a_we),      32'd0);
    chk({tag, "_b_we"},        32'(b_we),      32'd0);
    chk({tag, "_start"},       32'(start),     32'd0);
    chk({tag, "_busy"},        32'(busy),      32'd0);
    chk({tag, "_run_done"},    32'(run_done),  32'd0);
    chk({tag, "_mem_addr"},    32'(mem_addr),  32'd0);
    chk({tag, "_mem_wdata"},   32'(mem_wdata), 32'd0);
    chk({tag, "_cycle_count"}, cycle_count,    32'd0);
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1;
    @(negedge clk) go = 0;
    chk("busy_after_go", 32'(busy), 32'd1);
  endtask

  // Element i of the stream belongs to B when i >= N*N and lands at address i mod N*N.
  task automatic stream(input int n, input int duty, input bit idx_data, input int go_at, input bit tail);
    int acc = 0;
    int g = 0;
    bit fired = 0;
    wr_t w;
    while (acc < n && g < 20000) begin
      @(negedge clk);
      g++;
      go = (acc == go_at) && !fired;
      if (go) fired = 1;
      s_valid = ($urandom_range(99) < duty);
      s_data  = idx_data ? 8'(acc) : 8'($urandom);
      #1;
      if (s_valid && s_ready) begin
        w.is_b = (acc >= NN);
        w.addr = 8'(acc % NN);
        w.data = s_data;
        exp_q.push_back(w);
        last_acc_cyc = cyc;
        acc++;
      end
    end
    chk("stream_accepted", acc, n);
    @(negedge clk);
    go = 0;
    if (tail) begin
      s_valid = 1;
      s_data  = 8'hA5;
      #1;
      chk("s_ready_after_last", 32'(s_ready), 32'd0);
      repeat (4) @(negedge clk);
    end
    s_valid = 0;
  endtask

  // Compute-unit model: cu_done is driven relative to the start pulse; k counts clock edges after start.
  task automatic compute(input bit held, input int drop_k, input int rise_k, input bit go_in_wait);
    int g = 0;
    int exp_cnt = -1;
    int done0 = n_done;
    bit seen_low = 0;
    bit lvl;
    // expected latency: cycles after start until done is high having been low earlier in this run
    for (int k = 1; k <= rise_k + 1 && exp_cnt < 0; k++) begin
      lvl = held ? (k < drop_k || k >= rise_k) : (k >= rise_k);
      if (seen_low && lvl) exp_cnt = k - 1;
      if (!lvl) seen_low = 1;
    end
    while (!start && g < 5000) begin
      @(negedge clk);
      g++;
    end
    chk("start_seen", 32'(start), 32'd1);
    for (int k = 1; k <= rise_k; k++) begin
      @(posedge clk);
      #1;
      if (held && k == drop_k) cu_done = 0;
      if (k == rise_k) cu_done = 1;
      if (go_in_wait) begin
        go = (k == 10);
        if (k == 11) chk("busy_in_wait", 32'(busy), 32'd1);
      end
    end
    g = 0;
    while (!run_done && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("run_done_seen", 32'(run_done), 32'd1);
    chk("cycle_count", cycle_count, exp_cnt);
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("run_done_once", n_done - done0, 32'd1);
  endtask

  task automatic full_run(input int duty, input bit idx_data, input int go_at, input bit held,
                          input int drop_k, input int rise_k, input bit go_w, input int exp_cc);
    int a0 = n_a;
    int b0 = n_b;
    int s0 = n_start;
    pulse_go();
    fork
      stream(2 * NN, duty, idx_data, go_at, 1'b1);
      compute(held, drop_k, rise_k, go_w);
    join
    chk("a_writes", n_a - a0, NN);
    chk("b_writes", n_b - b0, NN);
    chk("start_pulses", n_start - s0, 32'd1);
    chk("start_timing", start_cyc, last_acc_cyc + 1);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("cycle_count_abs", cycle_count, exp_cc);
  endtask

  initial begin
    clk = 0;
    rst = 0;
    go = 0;
    s_valid = 0;
    s_data = 0;
    cu_done = 0;
    #2 rst = 1;
    #1 check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 0;

    // continuous stream, index data, done rises after 100 counted cycles
    full_run(100, 1'b1, -1, 1'b0, 0, 101, 1'b0, 100);

    // gapped stream, random data, go during LOAD_B and WAIT, done held over from previous run
    full_run(50, 1'b0, 400, 1'b1, 3, 51, 1'b1, 50);
    cu_done = 0;
    repeat (3) @(negedge clk);
    chk("cycle_count_idle_hold", cycle_count, 32'd50);

    // abort at element 300 while a B write strobe is high
    pulse_go();
    stream(300, 70, 1'b0, -1, 1'b0);
    chk("b_we_before_abort", 32'(b_we), 32'd1);
    #2 rst = 1;
    #1 check_idle_outputs("abort");
    chk("queue_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;

    // restart after abort begins again at A address 0
    full_run(100, 1'b1, -1, 1'b0, 0, 101, 1'b0, 100);

    // go and rst in the same cycle
    @(negedge clk);
    go = 1;
    rst = 1;
    @(negedge clk);
    go = 0;
    rst = 0;
    repeat (2) @(negedge clk);
    chk("go_rst_busy", 32'(busy), 32'd0);
    chk("go_rst_s_ready", 32'(s_ready), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
